regfile_dump: RTL and testbench

- Debug reader for the CPU register file: on command, walks a range of register addresses through one combinational read port and streams (address, data) pairs out over a valid/ready interface.
- Sits between the register file's spare read port and a debug transmitter (e.g. UART framer).
- Asserts `freeze` while active, so the control unit holds off register writes and the dump is a consistent snapshot.

---
 rtl/regfile_dump.sv | 120 ++++++++++++
 tb/tb_regfile_dump.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// Register file dump engine: walks a register index range through a spare
// combinational read port and streams (address, data) beats over valid/ready.
module regfile_dump #(
    parameter int WIDTH = 8,
    parameter int NREGS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       first,
    input  logic [3:0]       last,
    output logic [3:0]       ra,
    input  logic [WIDTH-1:0] rd,
    output logic [3:0]       out_addr,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             freeze,
    output logic             busy,
    output logic             done
);

    // The address path is a fixed 4 bits, so larger register files cannot be covered.
    generate
        if (NREGS < 1 || NREGS > 16) begin : g_nregs_check
            $error("regfile_dump: NREGS must be in 1..16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [3:0]       idx_reg, idx_next;
    logic [3:0]       end_reg, end_next;
    logic [3:0]       out_addr_reg, out_addr_next;
    logic [WIDTH-1:0] out_data_reg, out_data_next;
    logic             out_valid_reg, out_valid_next;
    logic             handshake;

    assign handshake = out_valid_reg && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            idx_reg       <= 4'd0;
            end_reg       <= 4'd0;
            out_addr_reg  <= 4'd0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            end_reg       <= end_next;
            out_addr_reg  <= out_addr_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        end_next       = end_reg;
        out_addr_next  = out_addr_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (first <= last) begin
                        idx_next   = first;
                        end_next   = last;
                        state_next = READ;
                    end else begin
                        state_next = FIN;
                    end
                end
            end
            READ: begin
                out_data_next  = rd;
                out_addr_next  = idx_reg;
                out_valid_next = 1'b1;
                state_next     = SEND;
            end
            SEND: begin
                // Termination by equality keeps index 15 from wrapping to 0.
                if (handshake) begin
                    out_valid_next = 1'b0;
                    if (idx_reg == end_reg) begin
                        state_next = FIN;
                    end else begin
                        idx_next   = idx_reg + 4'd1;
                        state_next = READ;
                    end
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ra        = idx_reg;
    assign out_addr  = out_addr_reg;
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign freeze    = (state_reg != IDLE);
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == FIN);

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: directed dumps plus randomized ranges, register
// contents and backpressure, checked against a queue-based beat model.
module tb_regfile_dump;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [3:0]       first;
    logic [3:0]       last;
    logic [3:0]       ra;
    logic [WIDTH-1:0] rd;
    logic [3:0]       out_addr;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             freeze;
    logic             busy;
    logic             done;

    logic [WIDTH-1:0] regb [16];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Register file model: combinational read, register 0 reads as zero.
    assign rd = (ra == 4'd0) ? '0 : regb[ra];

    regfile_dump #(.WIDTH(WIDTH), .NREGS(16)) dut (
        .clk(clk), .reset(reset), .start(start), .first(first), .last(last),
        .ra(ra), .rd(rd), .out_addr(out_addr), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .freeze(freeze),
        .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] ref_data(input int a);
        return (a == 0) ? '0 : regb[a];
    endfunction

    // mode 0: ready always high, mode 1: random ready.
    // stall_addr/stall_len hold ready low for that many cycles on that beat.
    task automatic run_dump(input int f, input int l, input int mode,
                            input int stall_addr, input int stall_len,
                            input bit inject_start);
        int  q[$];
        int  stalls = 0;
        int  fz = 0;
        int  guard = 0;
        int  stall_left = stall_len;
        int  n;
        bit  hs;
        bit  held = 0;
        bit  rdy;
        for (int a = f; a <= l; a++) q.push_back(a);
        n = q.size();
        first = 4'(f);
        last  = 4'(l);
        start = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        first = 4'($urandom_range(0, 15));
        last  = 4'($urandom_range(0, 15));
        while (1) begin
            guard++;
            if (guard > 3000) begin
                check("dump_timeout", 32'(guard), 32'd0);
                break;
            end
            hs = 0;
            if (freeze) fz++;
            check("busy_eq_freeze", 32'(busy), 32'(freeze));
            if (q.size() == 0) begin
                check("fin_done", 32'(done), 32'd1);
                check("fin_valid", 32'(out_valid), 32'd0);
                check("fin_freeze", 32'(freeze), 32'd1);
                break;
            end
            check("mid_done", 32'(done), 32'd0);
            if (held) check("valid_held", 32'(out_valid), 32'd1);
            start = (inject_start && guard == 3) ? 1'b1 : 1'b0;
            if (out_valid) begin
                check("beat_addr", 32'(out_addr), 32'(q[0]));
                check("beat_data", 32'(out_data), 32'(ref_data(q[0])));
                if (q[0] == stall_addr && stall_left > 0) begin
                    rdy = 0;
                    stall_left--;
                end else if (mode == 1) begin
                    rdy = 1'($urandom_range(0, 1));
                end else begin
                    rdy = 1;
                end
                if (!rdy) stalls++;
                hs = rdy;
                held = !rdy;
                out_ready = rdy;
            end else begin
                held = 0;
                out_ready = 1'($urandom_range(0, 1));
            end
            tick();
            if (hs) void'(q.pop_front());
        end
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        check("post_done", 32'(done), 32'd0);
        check("post_freeze", 32'(freeze), 32'd0);
        check("post_valid", 32'(out_valid), 32'd0);
        check("freeze_cycles", 32'(fz), 32'(2 * n + stalls + 1));
        $display("dump first=%0d last=%0d beats=%0d stalls=%0d freeze_cycles=%0d", f, l, n, stalls, fz);
    endtask

    initial begin
        int rf, rl;
        reset = 1'b1;
        start = 1'b0;
        first = 4'd0;
        last  = 4'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) regb[i] = WIDTH'(i * 3);
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_freeze", 32'(freeze), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ra", 32'(ra), 32'd0);
        check("rst_addr", 32'(out_addr), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        reset = 1'b0;
        tick();

        run_dump(0, 15, 0, -1, 0, 0);
        run_dump(5, 5, 0, -1, 0, 0);
        run_dump(15, 15, 0, -1, 0, 0);

        // Empty range: one FIN cycle, no beats.
        first = 4'd9;
        last  = 4'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("empty_done", 32'(done), 32'd1);
        check("empty_freeze", 32'(freeze), 32'd1);
        check("empty_valid", 32'(out_valid), 32'd0);
        tick();
        check("empty_done_end", 32'(done), 32'd0);
        check("empty_freeze_end", 32'(freeze), 32'd0);
        check("empty_valid_end", 32'(out_valid), 32'd0);
        $display("dump first=9 last=4 beats=0");

        run_dump(0, 5, 0, 2, 7, 0);
        run_dump(0, 3, 0, -1, 0, 1);

        // Reset while presenting the beat for register 7.
        first = 4'd0;
        last  = 4'd15;
        start = 1'b1;
        out_ready = 1'b0;
        tick();
        start = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (out_valid && out_addr == 4'd7) break;
            out_ready = out_valid;
            tick();
            out_ready = 1'b0;
        end
        check("pre_rst_addr", 32'(out_addr), 32'd7);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_freeze", 32'(freeze), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("abort_no_done", 32'(done), 32'd0);
        end
        $display("reset abort during addr 7");
        run_dump(0, 1, 0, -1, 0, 0);

        // Randomized contents, ranges and backpressure.
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 16; i++) regb[i] = WIDTH'($urandom);
            rf = $urandom_range(0, 15);
            rl = $urandom_range(rf, 15);
            run_dump(rf, rl, 1, $urandom_range(0, 15), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
